llc_snoop_responder: RTL and testbench

//  Responder side of the shared-bus snoop protocol for the 16-way MESI last-level cache.
//  It accepts bus operations issued by other processors, looks up the set in the external tag store, and returns NOHIT/HIT/HITM.
//  It downgrades or invalidates the matching line and drives the L1 messages and the dirty-line writeback.
//  It sits between the bus snoop port, the tag/MESI array and the L1 message channel.

---
 rtl/llc_snoop_responder_if.sv | 45 ++++
 rtl/llc_snoop_responder.sv | 178 +++++++++++++++++
 tb/tb_llc_snoop_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/llc_snoop_responder_if.sv
// Snoop-port, tag-store and L1/writeback channel bundle for the LLC snoop responder.
interface llc_snoop_responder_if #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 14,
    parameter int TAG_BITS   = 12,
    parameter int WAYS       = 16
);
    localparam int WAY_W = $clog2(WAYS);

    logic                           snp_valid;
    logic                           snp_ready;
    logic [1:0]                     snp_op;
    logic [ADDR_W-1:0]              snp_addr;
    logic                           tag_rd_en;
    logic [INDEX_BITS-1:0]          tag_rd_idx;
    logic [WAYS*(TAG_BITS+2)-1:0]   tag_rd_set;
    logic                           tag_wr_en;
    logic [INDEX_BITS-1:0]          tag_wr_idx;
    logic [WAY_W-1:0]               tag_wr_way;
    logic [1:0]                     tag_wr_mesi;
    logic                           snp_rsp_valid;
    logic [1:0]                     snp_result;
    logic                           l1_msg_valid;
    logic [1:0]                     l1_msg;
    logic [ADDR_W-1:0]              l1_msg_addr;
    logic                           l1_msg_ack;
    logic                           wb_valid;
    logic [ADDR_W-1:0]              wb_addr;
    logic                           wb_ack;
    logic                           multi_hit_err;

    modport slave (
        input  snp_valid, snp_op, snp_addr, tag_rd_set, l1_msg_ack, wb_ack,
        output snp_ready, tag_rd_en, tag_rd_idx, tag_wr_en, tag_wr_idx, tag_wr_way,
               tag_wr_mesi, snp_rsp_valid, snp_result, l1_msg_valid, l1_msg,
               l1_msg_addr, wb_valid, wb_addr, multi_hit_err
    );

    modport master (
        output snp_valid, snp_op, snp_addr, tag_rd_set, l1_msg_ack, wb_ack,
        input  snp_ready, tag_rd_en, tag_rd_idx, tag_wr_en, tag_wr_idx, tag_wr_way,
               tag_wr_mesi, snp_rsp_valid, snp_result, l1_msg_valid, l1_msg,
               l1_msg_addr, wb_valid, wb_addr, multi_hit_err
    );
endinterface

// File: rtl/llc_snoop_responder.sv
// MESI snoop responder: tag lookup, NOHIT/HIT/HITM response, line downgrade/invalidate,
// L1 GETLINE/INVALIDATELINE messaging and dirty-line writeback. One snoop in flight.
module llc_snoop_responder #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 14,
    parameter int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS,
    parameter int WAYS        = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    llc_snoop_responder_if.slave bus
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int ENT_W  = TAG_BITS + 2;
    localparam int LINE_W = ADDR_W - OFFSET_BITS;

    localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INV = 2'd2, OP_RWIM = 2'd3;
    localparam logic [1:0] ST_M = 2'd0, ST_E = 2'd1, ST_S = 2'd2, ST_I = 2'd3;
    localparam logic [1:0] RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2;
    localparam logic [1:0] MSG_GETLINE = 2'd0, MSG_INVLINE = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_GETL, S_WB, S_INVL, S_RESP} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [LINE_W-1:0]  r_line;
    logic [WAY_W-1:0]   r_way;
    logic [1:0]         r_result, r_new;
    logic               r_upd, r_inv;

    logic               w_hit, w_multi, w_getl, w_inv;
    logic [WAY_W-1:0]   w_way;
    logic [1:0]         w_old, w_new, w_res;
    logic [ENT_W-1:0]   w_ent;
    logic [ADDR_W-1:0]  w_line_addr;
    logic               w_unused;

    assign w_unused    = ^bus.snp_addr[OFFSET_BITS-1:0];
    assign w_line_addr = {r_line, {OFFSET_BITS{1'b0}}};

    // Scan high-to-low so the lowest-numbered matching way is the one left selected.
    always_comb begin
        w_hit   = 1'b0;
        w_multi = 1'b0;
        w_way   = '0;
        w_old   = ST_I;
        w_ent   = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            w_ent = bus.tag_rd_set[ENT_W*w +: ENT_W];
            if (w_ent[1:0] != ST_I && w_ent[ENT_W-1:2] == r_line[LINE_W-1 -: TAG_BITS]) begin
                if (w_hit) w_multi = 1'b1;
                w_hit = 1'b1;
                w_way = WAY_W'(w);
                w_old = w_ent[1:0];
            end
        end
    end

    always_comb begin
        w_res  = RES_NOHIT;
        w_new  = w_old;
        w_getl = 1'b0;
        w_inv  = 1'b0;
        if (w_hit) begin
            case (r_op)
                OP_READ: begin
                    w_res  = (w_old == ST_M) ? RES_HITM : RES_HIT;
                    w_new  = ST_S;
                    w_getl = (w_old == ST_M);
                end
                OP_RWIM: begin
                    w_res  = (w_old == ST_M) ? RES_HITM : RES_HIT;
                    w_new  = ST_I;
                    w_getl = (w_old == ST_M);
                    w_inv  = 1'b1;
                end
                OP_INV: begin
                    if (w_old == ST_S) begin
                        w_res = RES_HIT;
                        w_new = ST_I;
                        w_inv = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_WRITE;
            r_line   <= '0;
            r_way    <= '0;
            r_result <= RES_NOHIT;
            r_new    <= ST_I;
            r_upd    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.snp_valid) begin
                r_op   <= bus.snp_op;
                r_line <= bus.snp_addr[ADDR_W-1:OFFSET_BITS];
            end
            if (r_state == S_CMP) begin
                r_way    <= w_way;
                r_result <= w_res;
                r_new    <= w_new;
                r_upd    <= (w_new != w_old);
                r_inv    <= w_inv;
            end
        end
    end

    always_comb begin
        w_next             = r_state;
        bus.snp_ready      = 1'b0;
        bus.tag_rd_en      = 1'b0;
        bus.tag_rd_idx     = '0;
        bus.tag_wr_en      = 1'b0;
        bus.tag_wr_idx     = '0;
        bus.tag_wr_way     = '0;
        bus.tag_wr_mesi    = '0;
        bus.snp_rsp_valid  = 1'b0;
        bus.snp_result     = RES_NOHIT;
        bus.l1_msg_valid   = 1'b0;
        bus.l1_msg         = MSG_GETLINE;
        bus.l1_msg_addr    = '0;
        bus.wb_valid       = 1'b0;
        bus.wb_addr        = '0;
        bus.multi_hit_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.snp_ready = 1'b1;
                if (bus.snp_valid) w_next = S_RD;
            end
            S_RD: begin
                bus.tag_rd_en  = 1'b1;
                bus.tag_rd_idx = r_line[INDEX_BITS-1:0];
                w_next         = S_CMP;
            end
            S_CMP: begin
                bus.multi_hit_err = w_multi;
                w_next = w_getl ? S_GETL : (w_inv ? S_INVL : S_RESP);
            end
            S_GETL: begin
                bus.l1_msg_valid = 1'b1;
                bus.l1_msg       = MSG_GETLINE;
                bus.l1_msg_addr  = w_line_addr;
                if (bus.l1_msg_ack) w_next = S_WB;
            end
            S_WB: begin
                bus.wb_valid = 1'b1;
                bus.wb_addr  = w_line_addr;
                if (bus.wb_ack) w_next = r_inv ? S_INVL : S_RESP;
            end
            S_INVL: begin
                bus.l1_msg_valid = 1'b1;
                bus.l1_msg       = MSG_INVLINE;
                bus.l1_msg_addr  = w_line_addr;
                if (bus.l1_msg_ack) w_next = S_RESP;
            end
            S_RESP: begin
                bus.snp_rsp_valid = 1'b1;
                bus.snp_result    = r_result;
                if (r_upd) begin
                    bus.tag_wr_en   = 1'b1;
                    bus.tag_wr_idx  = r_line[INDEX_BITS-1:0];
                    bus.tag_wr_way  = r_way;
                    bus.tag_wr_mesi = r_new;
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_llc_snoop_responder.sv
// Directed vector bench for llc_snoop_responder: per-op/per-state table plus reset and
// delayed-writeback sequences.
module tb_llc_snoop_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    llc_snoop_responder_if bus ();
    llc_snoop_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        int          way_a;
        logic [11:0] tag_a;
        logic [1:0]  mesi_a;
        bit          use_b;
        int          way_b;
        logic [1:0]  res;
        bit          wr;
        int          wr_way;
        logic [1:0]  wr_mesi;
        int          lat;
        bit          getl;
        bit          wb;
        bit          inv;
        bit          multi;
    } vec_t;

    vec_t vt[13];

    // observations from the last snoop
    int          o_lat, o_wbcnt;
    logic [1:0]  o_res, o_wr_mesi;
    logic [3:0]  o_wr_way;
    logic [13:0] o_wr_idx;
    logic [31:0] o_wbaddr;
    bit o_wr, o_getl, o_inv, o_multi, o_rd_ok, o_ready_bad, o_both, o_stray_wr;
    bit o_wb_unstable, o_l1addr_bad, o_ready_after;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr, input int way_a,
                                input logic [11:0] tag_a, input logic [1:0] mesi_a, input bit use_b,
                                input int way_b, input logic [1:0] res, input bit wr, input int wr_way,
                                input logic [1:0] wr_mesi, input int lat, input bit getl, input bit wb,
                                input bit inv, input bit multi);
        vec_t v;
        v.op = op; v.addr = addr; v.way_a = way_a; v.tag_a = tag_a; v.mesi_a = mesi_a;
        v.use_b = use_b; v.way_b = way_b; v.res = res; v.wr = wr; v.wr_way = wr_way;
        v.wr_mesi = wr_mesi; v.lat = lat; v.getl = getl; v.wb = wb; v.inv = inv; v.multi = multi;
        return v;
    endfunction

    task automatic set_store(input int way_a, input logic [11:0] tag, input logic [1:0] mesi,
                             input bit use_b, input int way_b);
        logic [223:0] s;
        for (int w = 0; w < 16; w++) s[14*w +: 14] = {12'h000, 2'd3};
        s[14*way_a +: 14] = {tag, mesi};
        if (use_b) s[14*way_b +: 14] = {tag, mesi};
        bus.tag_rd_set = s;
    endtask

    task automatic run_snoop(input logic [1:0] op, input logic [31:0] addr, input int wb_delay);
        o_lat = 0; o_wbcnt = 0; o_res = 0; o_wr = 0; o_wr_way = 0; o_wr_idx = 0; o_wr_mesi = 0;
        o_wbaddr = 0; o_getl = 0; o_inv = 0; o_multi = 0; o_rd_ok = 0; o_ready_bad = 0;
        o_both = 0; o_stray_wr = 0; o_wb_unstable = 0; o_l1addr_bad = 0; o_ready_after = 0;
        @(negedge clk);
        bus.snp_valid = 1'b1;
        bus.snp_op    = op;
        bus.snp_addr  = addr;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.snp_valid = 1'b0;
                o_rd_ok = bus.tag_rd_en && (bus.tag_rd_idx == addr[19:6]);
            end
            if (bus.l1_msg_valid && bus.wb_valid) o_both = 1;
            if (bus.multi_hit_err) o_multi = 1;
            if (bus.l1_msg_valid) begin
                if (bus.l1_msg == 2'd0) o_getl = 1;
                else if (bus.l1_msg == 2'd2) o_inv = 1;
                else o_l1addr_bad = 1;
                if (bus.l1_msg_addr != {addr[31:6], 6'b0}) o_l1addr_bad = 1;
            end
            if (bus.wb_valid) begin
                o_wbcnt++;
                if (o_wbcnt == 1) o_wbaddr = bus.wb_addr;
                else if (bus.wb_addr != o_wbaddr) o_wb_unstable = 1;
                bus.wb_ack = (o_wbcnt > wb_delay);
            end else begin
                bus.wb_ack = 1'b0;
            end
            if (bus.snp_rsp_valid) begin
                o_lat = k; o_res = bus.snp_result; o_wr = bus.tag_wr_en;
                o_wr_way = bus.tag_wr_way; o_wr_idx = bus.tag_wr_idx; o_wr_mesi = bus.tag_wr_mesi;
                break;
            end
            if (bus.snp_ready) o_ready_bad = 1;
            if (bus.tag_wr_en) o_stray_wr = 1;
        end
        @(negedge clk);
        o_ready_after = bus.snp_ready;
        bus.wb_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bit seen;
        int wbc;
        a = 32'h1234_5678;
        //             op    addr          wayA tagA     mesiA ub wb res  wr way mesi lat g  w  i  m
        vt[0]  = mk(2'd0, a,            3, 12'h123, 2'd1, 0, 0, 2'd1, 1, 3,  2'd2, 3, 0, 0, 0, 0);
        vt[1]  = mk(2'd0, a,            3, 12'h123, 2'd2, 0, 0, 2'd1, 0, 0,  2'd0, 3, 0, 0, 0, 0);
        vt[2]  = mk(2'd0, a,            3, 12'h123, 2'd0, 0, 0, 2'd2, 1, 3,  2'd2, 5, 1, 1, 0, 0);
        vt[3]  = mk(2'd3, a,            3, 12'h123, 2'd0, 0, 0, 2'd2, 1, 3,  2'd3, 6, 1, 1, 1, 0);
        vt[4]  = mk(2'd3, a,            7, 12'h123, 2'd1, 0, 0, 2'd1, 1, 7,  2'd3, 4, 0, 0, 1, 0);
        vt[5]  = mk(2'd2, a,            3, 12'h123, 2'd2, 0, 0, 2'd1, 1, 3,  2'd3, 4, 0, 0, 1, 0);
        vt[6]  = mk(2'd2, a,            3, 12'h123, 2'd1, 0, 0, 2'd0, 0, 0,  2'd0, 3, 0, 0, 0, 0);
        vt[7]  = mk(2'd2, a,            3, 12'h123, 2'd0, 0, 0, 2'd0, 0, 0,  2'd0, 3, 0, 0, 0, 0);
        vt[8]  = mk(2'd2, a,            3, 12'h123, 2'd3, 0, 0, 2'd0, 0, 0,  2'd0, 3, 0, 0, 0, 0);
        vt[9]  = mk(2'd0, a,            3, 12'h124, 2'd1, 0, 0, 2'd0, 0, 0,  2'd0, 3, 0, 0, 0, 0);
        vt[10] = mk(2'd1, a,            3, 12'h123, 2'd0, 0, 0, 2'd0, 0, 0,  2'd0, 3, 0, 0, 0, 0);
        vt[11] = mk(2'd0, a,            9, 12'h123, 2'd1, 1, 2, 2'd1, 1, 2,  2'd2, 3, 0, 0, 0, 1);
        vt[12] = mk(2'd3, 32'hFFFF_FFC0, 15, 12'hFFF, 2'd1, 0, 0, 2'd1, 1, 15, 2'd3, 4, 0, 0, 1, 0);

        bus.snp_valid = 0; bus.snp_op = 0; bus.snp_addr = 0;
        bus.l1_msg_ack = 0; bus.wb_ack = 0; bus.tag_rd_set = '0;
        #1;
        chk("rst_ready", bus.snp_ready, 1);
        chk("rst_outs", {bus.tag_rd_en, bus.tag_wr_en, bus.snp_rsp_valid, bus.l1_msg_valid,
                         bus.wb_valid, bus.multi_hit_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.l1_msg_ack = 1'b1;   // held high: ack while valid=0 must be ignored

        for (int i = 0; i < 13; i++) begin
            set_store(vt[i].way_a, vt[i].tag_a, vt[i].mesi_a, vt[i].use_b, vt[i].way_b);
            run_snoop(vt[i].op, vt[i].addr, 0);
            chk($sformatf("v%0d_lat", i), o_lat, vt[i].lat);
            chk($sformatf("v%0d_res", i), o_res, vt[i].res);
            chk($sformatf("v%0d_wr", i), o_wr, vt[i].wr);
            if (vt[i].wr) begin
                chk($sformatf("v%0d_wr_way", i), o_wr_way, vt[i].wr_way);
                chk($sformatf("v%0d_wr_mesi", i), o_wr_mesi, vt[i].wr_mesi);
                chk($sformatf("v%0d_wr_idx", i), o_wr_idx, vt[i].addr[19:6]);
            end
            chk($sformatf("v%0d_msgs", i), {o_getl, o_wbcnt != 0, o_inv}, {vt[i].getl, vt[i].wb, vt[i].inv});
            if (vt[i].wb)
                chk($sformatf("v%0d_wb_addr", i), o_wbaddr, {vt[i].addr[31:6], 6'b0});
            chk($sformatf("v%0d_multi", i), o_multi, vt[i].multi);
            chk($sformatf("v%0d_rd", i), o_rd_ok, 1);
            chk($sformatf("v%0d_proto", i), {o_ready_bad, o_both, o_stray_wr, o_l1addr_bad}, 0);
            chk($sformatf("v%0d_ready_next", i), o_ready_after, 1);
        end

        // READ to M with writeback ack held off for 5 cycles
        set_store(3, 12'h123, 2'd0, 0, 0);
        run_snoop(2'd0, a, 5);
        chk("dly_wbcnt", o_wbcnt, 6);
        chk("dly_wb_addr", o_wbaddr, 32'h1234_5640);
        chk("dly_wb_stable", o_wb_unstable, 0);
        chk("dly_ready", o_ready_bad, 0);
        chk("dly_res", o_res, 2);
        chk("dly_lat", o_lat, 10);
        chk("dly_wr", {o_wr, o_wr_mesi}, {1'b1, 2'd2});

        // reset asserted while parked in WB
        seen = 0;
        @(negedge clk);
        bus.snp_valid = 1'b1; bus.snp_op = 2'd0; bus.snp_addr = a;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.snp_valid = 1'b0;
            if (bus.wb_valid) begin seen = 1; break; end
        end
        chk("rstwb_reached", seen, 1);
        repeat (2) @(negedge clk);
        chk("rstwb_held", bus.wb_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstwb_outs", {bus.wb_valid, bus.l1_msg_valid, bus.tag_wr_en, bus.snp_rsp_valid,
                           bus.tag_rd_en, bus.multi_hit_err}, 0);
        chk("rstwb_addr", bus.wb_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wbc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.tag_wr_en || bus.snp_rsp_valid || bus.wb_valid) wbc++;
        end
        chk("rstwb_quiet", wbc, 0);
        chk("rstwb_ready", bus.snp_ready, 1);

        // normal operation resumes after reset
        set_store(3, 12'h123, 2'd1, 0, 0);
        run_snoop(2'd0, a, 0);
        chk("post_rst_res", {o_res, o_wr, o_wr_mesi}, {2'd1, 1'b1, 2'd2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
